// File: rtl/uart_rx_core_if.sv
// Push interface from the UART receiver into the RX FIFO: byte, push strobe,
// per-frame status pulses, and the FIFO-full back-pressure signal.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_full;
  logic                 frame_err;
  logic                 parity_err;
  logic                 break_det;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
    input  rx_full
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
    output rx_full
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchronises rx, recovers LSB-first frames at mid-bit,
// and pushes bytes plus framing/parity/break/overrun pulses toward the RX FIFO.
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int OVERSAMPLE  = 16,
  parameter int DIVISOR     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  output logic           busy,
  uart_rx_core_if.master push
);
  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);
  localparam logic [SW-1:0] SC_HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]        div_q, div_d;
  logic [SW-1:0]        sc_q, sc_d;
  logic [BW-1:0]        bc_q, bc_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q;
  logic                 par_q, par_d, perr_q, perr_d;
  logic                 pend_q, pend_d, ferr_q, ferr_d, pflag_q, pflag_d, brk_q, brk_d;
  logic                 rxs, tick, mid, accept;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign tick = (div_q == DIV_LAST);
  assign mid  = tick && (sc_q == SC_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    sc_d    = sc_q;
    bc_d    = bc_q;
    sh_d    = sh_q;
    par_d   = par_q;
    perr_d  = perr_q;
    pend_d  = 1'b0;
    ferr_d  = 1'b0;
    pflag_d = 1'b0;
    brk_d   = 1'b0;
    if (tick && state_q != IDLE) sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
    unique case (state_q)
      IDLE: if (!rxs) begin
        state_d = START;
        div_d   = '0;
      end
      // Half a bit into START puts every later sc==LAST tick at mid-bit.
      START: if (tick && sc_q == SC_HALF) state_d = rxs ? IDLE : DATA;
      DATA: if (mid) begin
        sh_d = {rxs, sh_q[DATA_BITS-1:1]};
        bc_d = bc_q + 1'b1;
        if (bc_q == BC_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (mid) begin
        par_d   = rxs;
        perr_d  = ((^sh_q) ^ rxs) != (PARITY_ODD != 0);
        state_d = STOP;
      end
      STOP: if (mid) begin
        pend_d  = 1'b1;
        pflag_d = (PARITY_EN != 0) && perr_q;
        if (rxs) state_d = IDLE;
        else begin
          ferr_d  = 1'b1;
          brk_d   = (sh_q == '0) && ((PARITY_EN == 0) || !par_q);
          state_d = BRK_WAIT;
        end
      end
      BRK_WAIT: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      sc_d = '0;
      bc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '1;
      div_q   <= '0;
      sc_q    <= '0;
      bc_q    <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      pend_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pflag_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      div_q   <= div_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      sh_q    <= sh_d;
      data_q  <= push.rx_data;
      par_q   <= par_d;
      perr_q  <= perr_d;
      pend_q  <= pend_d;
      ferr_q  <= ferr_d;
      pflag_q <= pflag_d;
      brk_q   <= brk_d;
    end
  end

  // rx_full is looked at in the push cycle itself, so the accept decision is combinational.
  assign accept          = pend_q & ~push.rx_full;
  assign push.rx_valid   = accept;
  assign push.overrun    = pend_q & push.rx_full;
  assign push.rx_data    = accept ? sh_q : data_q;
  assign push.frame_err  = ferr_q;
  assign push.parity_err = pflag_q;
  assign push.break_det  = brk_q;
  assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: dut0 is 8N1, dut1 is 8E1; a frame-level model
// predicts each strobe (content and arrival cycle) and the held rx_data.
module tb_uart_rx_core;
  localparam int BP   = 64;
  localparam int LAT0 = 2 + (8 + 9 * 16) * 4 + 1;
  localparam int LAT1 = 2 + (8 + 10 * 16) * 4 + 1;

  typedef struct {
    int         dut;
    logic [7:0] data;
    bit         full, ferr, perr, brk;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rxl = 2'b11;
  logic [1:0] full = 2'b00;
  logic [1:0] busy;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         lat;
  exp_t       expq[$];
  exp_t       ce;
  logic [7:0] mdl_data [2];
  logic [7:0] o_data [2];
  logic       o_vld [2], o_ovr [2], o_ferr [2], o_perr [2], o_brk [2];
  bit         last_ferr, last_perr, last_brk, last_ovr;

  uart_rx_core_if #(.DATA_BITS(8)) if0 ();
  uart_rx_core_if #(.DATA_BITS(8)) if1 ();

  uart_rx_core #(.PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .rx(rxl[0]), .busy(busy[0]), .push(if0)
  );
  uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .rx(rxl[1]), .busy(busy[1]), .push(if1)
  );

  assign if0.rx_full = full[0];
  assign if1.rx_full = full[1];
  assign o_data[0] = if0.rx_data;    assign o_data[1] = if1.rx_data;
  assign o_vld[0]  = if0.rx_valid;   assign o_vld[1]  = if1.rx_valid;
  assign o_ovr[0]  = if0.overrun;    assign o_ovr[1]  = if1.overrun;
  assign o_ferr[0] = if0.frame_err;  assign o_ferr[1] = if1.frame_err;
  assign o_perr[0] = if0.parity_err; assign o_perr[1] = if1.parity_err;
  assign o_brk[0]  = if0.break_det;  assign o_brk[1]  = if1.break_det;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected one within 100000 cycles");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Frame-level expectation: everything follows from what goes on the wire.
  task automatic send_frame(input int d, input logic [7:0] data, input bit par,
                            input bit stop, input bit keep_low, input int idle_bits);
    exp_t e;
    e.dut  = d;
    e.data = data;
    e.full = full[d];
    e.ferr = !stop;
    e.perr = (d == 1) && ((^data) ^ par);
    e.brk  = !stop && (data == 8'h00) && (d == 0 || !par);
    e.due  = cyc + ((d == 0) ? LAT0 : LAT1);
    expq.push_back(e);
    rxl[d] = 1'b0;
    hold(BP);
    for (int i = 0; i < 8; i++) begin
      rxl[d] = data[i];
      hold(BP);
    end
    if (d == 1) begin
      rxl[d] = par;
      hold(BP);
    end
    rxl[d] = stop;
    hold(BP);
    if (!keep_low) rxl[d] = 1'b1;
    hold(idle_bits * BP);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (o_vld[i] | o_ovr[i] | o_ferr[i] | o_perr[i] | o_brk[i]) begin
          if (expq.size() == 0 || expq[0].dut != i) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe dut%0d: got a strobe at cycle %0d, expected none", i, cyc);
          end else begin
            ce = expq.pop_front();
            chk("rx_valid", o_vld[i], !ce.full);
            chk("overrun", o_ovr[i], ce.full);
            chk("frame_err", o_ferr[i], ce.ferr);
            chk("parity_err", o_perr[i], ce.perr);
            chk("break_det", o_brk[i], ce.brk);
            lat = cyc - ce.due;
            n_chk++;
            if (lat < -1 || lat > 1) begin
              n_fail++;
              $display("FAIL latency dut%0d: got strobe %0d cycles off nominal, expected within +/-1", i, lat);
            end
            if (!ce.full) mdl_data[i] = ce.data;
            last_ferr = o_ferr[i];
            last_perr = o_perr[i];
            last_brk  = o_brk[i];
            last_ovr  = o_ovr[i];
          end
        end
        chk("rx_data_hold", o_data[i], mdl_data[i]);
      end
    end
  end

  initial begin
    mdl_data[0] = 8'h00;
    mdl_data[1] = 8'h00;
    hold(3);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_valid", if0.rx_valid, 1'b0);
    chk("rst_data", if0.rx_data, 8'h00);
    chk("rst_flags", {if0.frame_err, if0.parity_err, if0.break_det, if0.overrun}, 4'h0);
    rst = 1'b0;
    hold(2 * BP);

    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, 2);
    chk("t1_data", if0.rx_data, 8'h55);
    chk("t1_busy", busy[0], 1'b0);

    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, 0);
    send_frame(0, 8'hA3, 1'b0, 1'b1, 1'b0, 2);
    chk("b2b_data", if0.rx_data, 8'hA3);
    chk("b2b_ferr", last_ferr, 1'b0);

    rxl[0] = 1'b0;
    hold(10);
    chk("glitch_busy_hi", busy[0], 1'b1);
    hold(10);
    rxl[0] = 1'b1;
    hold(40);
    chk("glitch_busy_lo", busy[0], 1'b0);
    hold(BP);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0, 2);
    chk("after_glitch_data", if0.rx_data, 8'h3C);

    send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0, 2);
    chk("ferr_data", if0.rx_data, 8'hA3);
    chk("ferr_flag", last_ferr, 1'b1);
    chk("ferr_nobrk", last_brk, 1'b0);

    full[0] = 1'b1;
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, 0);
    full[0] = 1'b0;
    hold(2 * BP);
    chk("ovr_flag", last_ovr, 1'b1);
    chk("ovr_data_held", if0.rx_data, 8'hA3);

    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    hold(20 * BP);
    chk("brk_wait_busy", busy[0], 1'b1);
    chk("brk_flag", last_brk, 1'b1);
    rxl[0] = 1'b1;
    hold(2 * BP);
    chk("brk_release_busy", busy[0], 1'b0);
    send_frame(0, 8'h96, 1'b0, 1'b1, 1'b0, 2);
    chk("after_brk_data", if0.rx_data, 8'h96);

    rxl[0] = 1'b0;
    hold(BP);
    for (int i = 0; i < 4; i++) begin
      rxl[0] = (i < 2) ? 1'b1 : 1'b0;
      hold(BP);
    end
    rxl[0] = 1'b1;
    hold(BP / 2);
    chk("mid_frame_busy", busy[0], 1'b1);
    rst = 1'b1;
    mdl_data[0] = 8'h00;
    mdl_data[1] = 8'h00;
    hold(1);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_data", if0.rx_data, 8'h00);
    chk("midrst_strobes", {if0.rx_valid, if0.frame_err, if0.parity_err, if0.break_det, if0.overrun}, 5'h00);
    rst = 1'b0;
    hold(2 * BP);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 2);
    chk("after_rst_data", if0.rx_data, 8'h5A);

    send_frame(1, 8'hA3, 1'b0, 1'b1, 1'b0, 2);
    chk("par_ok_data", if1.rx_data, 8'hA3);
    chk("par_ok_flag", last_perr, 1'b0);
    send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b0, 2);
    chk("par_bad_flag", last_perr, 1'b1);

    chk("exp_queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
